// File: rtl/full_adder_16bits.sv
// One-bit full-adder cell; the ripple stage of the 16-bit add pipeline.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows inputs continuously.
module full_adder_1bit (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic s,
    output logic co
);
    logic p;

    assign p  = a ^ b;
    assign s  = p ^ c;
    assign co = (a & b) | (c & p);
endmodule

// 16-bit ripple-carry add stage with registered sum, carry-out and carry into bit 15.
// Latency: one core cycle from operands to s/cout/cout_1.
// Backpressure: none; samples a/b/cin on every rising clk edge.
module full_adder_16bits (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    output logic [15:0] s,
    output logic        cout,
    output logic        cout_1
);
    localparam int WIDTH = 16;

    // carry[i] is the carry into bit i; carry[WIDTH] leaves the MSB.
    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum;

    assign carry[0] = cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        full_adder_1bit u_cell (
            .a  (a[i]),
            .b  (b[i]),
            .c  (carry[i]),
            .s  (sum[i]),
            .co (carry[i+1])
        );
    end

    // cout ^ cout_1 gives signed overflow downstream.
    always_ff @(posedge clk) begin
        if (rst) begin
            s      <= '0;
            cout   <= 1'b0;
            cout_1 <= 1'b0;
        end else begin
            s      <= sum;
            cout   <= carry[WIDTH];
            cout_1 <= carry[WIDTH-1];
        end
    end
endmodule

// File: tb/tb_full_adder_16bits.sv
// Self-checking bench for full_adder_16bits against an arithmetic reference model.
module tb_full_adder_16bits;
    logic        clk;
    logic        rst;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] s;
    logic        cout;
    logic        cout_1;

    int n_checks = 0;
    int n_pass   = 0;

    full_adder_16bits dut (
        .clk    (clk),
        .rst    (rst),
        .a      (a),
        .b      (b),
        .cin    (cin),
        .s      (s),
        .cout   (cout),
        .cout_1 (cout_1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Returns {cout, cout_1, s} expected from one add with rst low.
    function automatic logic [17:0] ref_add(input logic [15:0] x, input logic [15:0] y,
                                            input logic ci);
        logic [16:0] full;
        logic [15:0] low;
        full = {1'b0, x} + {1'b0, y} + {16'b0, ci};
        low  = {1'b0, x[14:0]} + {1'b0, y[14:0]} + {15'b0, ci};
        return {full[16], low[15], full[15:0]};
    endfunction

    // Apply inputs away from the edge, then step past the next rising edge.
    task automatic step(input logic [15:0] x, input logic [15:0] y, input logic ci,
                        input logic r);
        @(negedge clk);
        a   = x;
        b   = y;
        cin = ci;
        rst = r;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [17:0] got;
        for (int i = 0; i < 2; i++) begin
            step(16'hFFFF, 16'hFFFF, 1'b1, 1'b1);
            got = {cout, cout_1, s};
            n_checks++;
            if (got !== 18'h0)
                $display("FAIL reset_%0d: got %h expected %h", i, got, 18'h0);
            else
                n_pass++;
        end
        // First edge out of reset loads the operands present at that edge.
        step(16'hFFFF, 16'hFFFF, 1'b1, 1'b0);
        got = {cout, cout_1, s};
        n_checks++;
        if (got !== {1'b1, 1'b1, 16'hFFFF})
            $display("FAIL reset_release: got %h expected %h", got, {1'b1, 1'b1, 16'hFFFF});
        else
            n_pass++;
    endtask

    task automatic test_directed();
        logic [15:0] va [5];
        logic [15:0] vb [5];
        logic        vc [5];
        logic [17:0] want [5];
        logic [17:0] got;
        va[0] = 16'h0001; vb[0] = 16'h0001; vc[0] = 1'b0; want[0] = {2'b00, 16'h0002};
        va[1] = 16'h0001; vb[1] = 16'h0001; vc[1] = 1'b1; want[1] = {2'b00, 16'h0003};
        va[2] = 16'h1234; vb[2] = 16'h1111; vc[2] = 1'b0; want[2] = {2'b00, 16'h2345};
        va[3] = 16'hFFFF; vb[3] = 16'h0001; vc[3] = 1'b0; want[3] = {2'b11, 16'h0000};
        va[4] = 16'h0000; vb[4] = 16'h0000; vc[4] = 1'b1; want[4] = {2'b00, 16'h0001};
        for (int i = 0; i < 5; i++) begin
            step(va[i], vb[i], vc[i], 1'b0);
            got = {cout, cout_1, s};
            n_checks++;
            if (got !== want[i])
                $display("FAIL directed_%0d: got %h expected %h", i, got, want[i]);
            else
                n_pass++;
        end
    endtask

    task automatic test_overflow();
        logic [17:0] got;
        step(16'h7FFF, 16'h0001, 1'b0, 1'b0);
        got = {cout, cout_1, s};
        n_checks++;
        if (got !== {1'b0, 1'b1, 16'h8000})
            $display("FAIL ovf_pos: got %h expected %h", got, {1'b0, 1'b1, 16'h8000});
        else
            n_pass++;
        step(16'h8000, 16'h8000, 1'b0, 1'b0);
        got = {cout, cout_1, s};
        n_checks++;
        if (got !== {1'b1, 1'b0, 16'h0000})
            $display("FAIL ovf_neg: got %h expected %h", got, {1'b1, 1'b0, 16'h0000});
        else
            n_pass++;
        step(16'hFFFF, 16'hFFFF, 1'b1, 1'b0);
        got = {cout, cout_1, s};
        n_checks++;
        if (got !== {1'b1, 1'b1, 16'hFFFF})
            $display("FAIL max_sum: got %h expected %h", got, {1'b1, 1'b1, 16'hFFFF});
        else
            n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [15:0] x;
        logic [15:0] y;
        logic        ci;
        logic        r;
        logic [17:0] want;
        logic [17:0] got;
        int          errs = 0;
        for (int i = 0; i < 1000; i++) begin
            x  = 16'($urandom);
            y  = 16'($urandom);
            ci = 1'($urandom);
            r  = ($urandom_range(0, 39) == 0);
            want = r ? 18'h0 : ref_add(x, y, ci);
            step(x, y, ci, r);
            got = {cout, cout_1, s};
            n_checks++;
            if (got !== want) begin
                if (errs < 10)
                    $display("FAIL b2b_%0d: a=%h b=%h cin=%0d rst=%0d got %h expected %h",
                             i, x, y, ci, r, got, want);
                errs++;
            end else begin
                n_pass++;
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        a   = '0;
        b   = '0;
        cin = 1'b0;
        test_reset();
        test_directed();
        test_overflow();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
